fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 211 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
//
// Purpose:
//   Instruction fetch front end. Keeps a fetch PC, issues one word-aligned
//   read per cycle to a single-cycle-latency instruction memory, and places
//   each returned word with its PC into a 2-entry output FIFO for decode.
//   Downstream redirects flush the FIFO, drop the response still in flight,
//   and restart fetching at the new target.
//
// Optional feature:
//   Define FETCH_PERF_CNT_EN to add two 32-bit performance counters and
//   their output ports (perf_fetched, perf_stall). The default build has
//   neither the ports nor the counters.
//
// Parameters:
//   RESET_PC        first fetch address after reset (low two bits ignored)
//
// Ports:
//   clk             single clock, all state updates on its rising edge
//   rstn            asynchronous active-low reset
//   imem_rd_en      instruction-memory read request this cycle
//   imem_addr       byte address of the request, always word aligned
//   imem_rdata      read data, valid one cycle after imem_rd_en
//   redirect_valid  branch/jump redirect request from downstream
//   redirect_pc     redirect target address
//   if_valid        if_pc/if_instr hold a valid instruction for decode
//   if_pc           address of the presented instruction
//   if_instr        presented instruction word
//   id_ready        decode accepts the presented instruction this cycle
//   perf_fetched    (FETCH_PERF_CNT_EN only) count of completed transfers
//   perf_stall      (FETCH_PERF_CNT_EN only) cycles decode was ready but
//                   no instruction was available
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    // Fetch PC and the single outstanding request
    logic [31:0] fetchPc_q;
    logic [31:0] fetchPc_d;
    logic        inflight_q;
    logic        inflight_d;
    logic [31:0] inflightPc_q;
    logic [31:0] inflightPc_d;

    // Two-entry output FIFO
    logic [31:0] fifoPc_q    [2];
    logic [31:0] fifoInstr_q [2];
    logic        rdPtr_q;
    logic        rdPtr_d;
    logic        wrPtr_q;
    logic        wrPtr_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    // Per-cycle control
    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  committed;

    // The two low bits of a redirect target are discarded on purpose.
    logic        unusedRedirectLsbs;
    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    // Handshake and issue decisions.
    // 'committed' is the number of FIFO slots that will be occupied once the
    // response in flight lands and this cycle's transfer (if any) retires.
    // Issuing only while it is below two means the FIFO can never overflow
    // and no response ever has to be dropped for lack of space. The reset
    // term keeps the request low while rstn is held, since the occupancy
    // terms alone would otherwise allow an issue.
    always_comb begin
        pop       = (count_q != 2'd0) && id_ready;
        push      = inflight_q && !redirect_valid;
        committed = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = rstn && !redirect_valid && (committed < 3'd2);
    end

    // Next-state for the fetch PC and the in-flight tracker.
    // A redirect loads the aligned target and issues nothing, so the target
    // goes out on the following cycle. Back-to-back redirects simply keep
    // overwriting the PC, leaving only the last target. The PC increment
    // wraps naturally at the top of the 32-bit address space.
    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = issue;
        inflightPc_d = inflightPc_q;
        if (redirect_valid) begin
            fetchPc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fetchPc_d = fetchPc_q + 32'd4;
        end
        if (issue) begin
            inflightPc_d = fetchPc_q;
        end
    end

    // Next-state for the FIFO pointers and occupancy.
    // A redirect empties the FIFO outright; an instruction decode accepts in
    // the same cycle is still treated as delivered (it is simply not kept).
    // The response arriving in a redirect cycle is not pushed, which is how
    // the in-flight request gets killed.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (redirect_valid) begin
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
            count_d = 2'd0;
        end else begin
            rdPtr_d = rdPtr_q ^ pop;
            wrPtr_d = wrPtr_q ^ push;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetchPc_q    <= ResetPcAligned;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'd0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage. Entries are cleared on reset so the presented PC and
    // instruction read as zero while reset is held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                fifoPc_q[i]    <= 32'd0;
                fifoInstr_q[i] <= 32'd0;
            end
        end else if (push) begin
            fifoPc_q[wrPtr_q]    <= inflightPc_q;
            fifoInstr_q[wrPtr_q] <= imem_rdata;
        end
    end

    // Memory request and decode-facing outputs.
    always_comb begin
        imem_rd_en = issue;
        imem_addr  = fetchPc_q;
        if_valid   = (count_q != 2'd0);
        if_pc      = fifoPc_q[rdPtr_q];
        if_instr   = fifoInstr_q[rdPtr_q];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfStall_q;

    // Transfers are counted even when a redirect flushes the FIFO in the same
    // cycle, because decode did take that instruction. Both counters wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perfFetched_q <= 32'd0;
            perfStall_q   <= 32'd0;
        end else begin
            if (pop) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (id_ready && (count_q == 2'd0)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_stall   = perfStall_q;
`endif

    // Structural invariants of the FIFO handshake.
    noOverflow : assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == 2'd2)));
    noUnderflow : assert property (@(posedge clk) disable iff (!rstn)
        !(pop && (count_q == 2'd0)));

endmodule

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit
//
// Directed testbench for fetch_unit. A behavioural instruction memory returns
// (address + 1) one cycle after each request, so every presented instruction
// word identifies the PC it came from. Inputs are driven one time unit after
// the rising edge and outputs are sampled there as well.
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        imemRdEn;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;
    logic        idReady;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched;
    logic [31:0] perfStall;
`endif

    int compared   = 0;
    int mismatched = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_rd_en    (imemRdEn),
        .imem_addr     (imemAddr),
        .imem_rdata    (imemRdata),
        .redirect_valid(redirectValid),
        .redirect_pc   (redirectPc),
        .if_valid      (ifValid),
        .if_pc         (ifPc),
        .if_instr      (ifInstr),
        .id_ready      (idReady)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perfFetched),
        .perf_stall    (perfStall)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: one-cycle read latency, data = address + 1
    initial imemRdata = 32'd0;
    always @(posedge clk) begin
        if (imemRdEn) begin
            imemRdata <= imemAddr + 32'd1;
        end
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release; returns in the first cycle
    // with rstn high
    task automatic doReset();
        rstn          = 1'b0;
        idReady       = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'd0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Reset values and the first instructions after release
    task automatic test_reset();
        rstn          = 1'b0;
        idReady       = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'd0;
        step();
        step();
        compared++;
        if (ifValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_if_valid: got %0b expected 0", ifValid);
        end
        compared++;
        if (imemRdEn !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_en: got %0b expected 0", imemRdEn);
        end
        compared++;
        if (ifPc !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_if_pc: got %h expected 00000000", ifPc);
        end
        compared++;
        if (ifInstr !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_if_instr: got %h expected 00000000", ifInstr);
        end
`ifdef FETCH_PERF_CNT_EN
        compared++;
        if (perfFetched !== 32'd0 || perfStall !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_perf: got %h/%h expected 0/0", perfFetched, perfStall);
        end
`endif
        rstn = 1'b1;
        #1;
        compared++;
        if (imemRdEn !== 1'b1 || imemAddr !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL first_issue: got en=%0b addr=%h expected en=1 addr=00000000",
                     imemRdEn, imemAddr);
        end
        step();
        compared++;
        if (ifValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL early_valid: got %0b expected 0", ifValid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (ifValid !== 1'b1 || ifPc !== 32'(4 * k) || ifInstr !== 32'(4 * k + 1)) begin
                mismatched++;
                $display("[TB] FAIL stream_%0d: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, ifValid, ifPc, ifInstr, 32'(4 * k), 32'(4 * k + 1));
            end
            step();
        end
    endtask

    // Decode back-pressure for five cycles while streaming
    task automatic test_stall();
        doReset();
        step();
        step();
        step();
        idReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (ifValid !== 1'b1 || ifPc !== 32'h4 || ifInstr !== 32'h5) begin
                mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got v=%0b pc=%h instr=%h expected v=1 pc=00000004 instr=00000005",
                         i, ifValid, ifPc, ifInstr);
            end
            if (i >= 1) begin
                compared++;
                if (imemRdEn !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_no_issue_%0d: got %0b expected 0", i, imemRdEn);
                end
            end
            step();
        end
        idReady = 1'b1;
        #1;
        compared++;
        if (imemRdEn !== 1'b1 || imemAddr !== 32'hC) begin
            mismatched++;
            $display("[TB] FAIL stall_resume_issue: got en=%0b addr=%h expected en=1 addr=0000000c",
                     imemRdEn, imemAddr);
        end
        for (int k = 1; k <= 4; k++) begin
            compared++;
            if (ifValid !== 1'b1 || ifPc !== 32'(4 * k)) begin
                mismatched++;
                $display("[TB] FAIL stall_resume_%0d: got v=%0b pc=%h expected v=1 pc=%h",
                         k, ifValid, ifPc, 32'(4 * k));
            end
            step();
        end
    endtask

    // Redirect while a response is in flight and the FIFO holds an entry
    task automatic test_redirect();
        doReset();
        step();
        step();
        step();
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0103;
        #1;
        compared++;
        if (imemRdEn !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL redir_no_issue: got %0b expected 0", imemRdEn);
        end
        step();
        redirectValid = 1'b0;
        #1;
        compared++;
        if (ifValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL redir_flush_1: got v=%0b pc=%h expected v=0", ifValid, ifPc);
        end
        compared++;
        if (imemRdEn !== 1'b1 || imemAddr !== 32'h0000_0100) begin
            mismatched++;
            $display("[TB] FAIL redir_target_issue: got en=%0b addr=%h expected en=1 addr=00000100",
                     imemRdEn, imemAddr);
        end
        step();
        compared++;
        if (ifValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL redir_flush_2: got v=%0b pc=%h expected v=0", ifValid, ifPc);
        end
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h100 || ifInstr !== 32'h101) begin
            mismatched++;
            $display("[TB] FAIL redir_target: got v=%0b pc=%h instr=%h expected v=1 pc=00000100 instr=00000101",
                     ifValid, ifPc, ifInstr);
        end
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h104) begin
            mismatched++;
            $display("[TB] FAIL redir_next: got v=%0b pc=%h expected v=1 pc=00000104", ifValid, ifPc);
        end
    endtask

    // Two consecutive redirects on a full FIFO; only the last target counts
    task automatic test_back_to_back_redirect();
        doReset();
        step();
        step();
        step();
        idReady = 1'b0;
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h4) begin
            mismatched++;
            $display("[TB] FAIL full_before_redir: got v=%0b pc=%h expected v=1 pc=00000004", ifValid, ifPc);
        end
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0200;
        step();
        redirectPc = 32'h0000_03FC;
        #1;
        compared++;
        if (ifValid !== 1'b0 || imemRdEn !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_flush: got v=%0b en=%0b expected v=0 en=0", ifValid, imemRdEn);
        end
        step();
        redirectValid = 1'b0;
        idReady       = 1'b1;
        #1;
        compared++;
        if (imemRdEn !== 1'b1 || imemAddr !== 32'h0000_03FC) begin
            mismatched++;
            $display("[TB] FAIL b2b_issue: got en=%0b addr=%h expected en=1 addr=000003fc",
                     imemRdEn, imemAddr);
        end
        step();
        compared++;
        if (ifValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_gap: got v=%0b pc=%h expected v=0", ifValid, ifPc);
        end
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h3FC || ifInstr !== 32'h3FD) begin
            mismatched++;
            $display("[TB] FAIL b2b_target: got v=%0b pc=%h instr=%h expected v=1 pc=000003fc instr=000003fd",
                     ifValid, ifPc, ifInstr);
        end
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h400) begin
            mismatched++;
            $display("[TB] FAIL b2b_next: got v=%0b pc=%h expected v=1 pc=00000400", ifValid, ifPc);
        end
    endtask

    // Fetch PC wrapping past the top of the address space
    task automatic test_wrap();
        logic [31:0] expPc [3];
        expPc[0] = 32'hFFFF_FFF8;
        expPc[1] = 32'hFFFF_FFFC;
        expPc[2] = 32'h0000_0000;
        doReset();
        step();
        step();
        step();
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFF8;
        step();
        redirectValid = 1'b0;
        #1;
        compared++;
        if (imemAddr !== 32'hFFFF_FFF8) begin
            mismatched++;
            $display("[TB] FAIL wrap_issue: got addr=%h expected fffffff8", imemAddr);
        end
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (ifValid !== 1'b1 || ifPc !== expPc[k] || ifInstr !== expPc[k] + 32'd1) begin
                mismatched++;
                $display("[TB] FAIL wrap_%0d: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, ifValid, ifPc, ifInstr, expPc[k], expPc[k] + 32'd1);
            end
            step();
        end
    endtask

    // Asynchronous reset pulse in the middle of a stream
    task automatic test_async_reset();
        doReset();
        step();
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        compared++;
        if (ifValid !== 1'b0 || imemRdEn !== 1'b0 || ifPc !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL async_drop: got v=%0b en=%0b pc=%h expected v=0 en=0 pc=00000000",
                     ifValid, imemRdEn, ifPc);
        end
        step();
        rstn = 1'b1;
        #1;
        compared++;
        if (imemRdEn !== 1'b1 || imemAddr !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL async_restart_issue: got en=%0b addr=%h expected en=1 addr=00000000",
                     imemRdEn, imemAddr);
        end
        step();
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'd0 || ifInstr !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL async_restart: got v=%0b pc=%h instr=%h expected v=1 pc=00000000 instr=00000001",
                     ifValid, ifPc, ifInstr);
        end
        step();
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h4) begin
            mismatched++;
            $display("[TB] FAIL async_restart_next: got v=%0b pc=%h expected v=1 pc=00000004", ifValid, ifPc);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    // Ten transfers, then a redirect that leaves decode starved for two more
    // cycles; the two cycles right after reset release are starved as well
    task automatic test_perf();
        doReset();
        compared++;
        if (perfFetched !== 32'd0 || perfStall !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL perf_start: got %0d/%0d expected 0/0", perfFetched, perfStall);
        end
        repeat (12) step();
        idReady       = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0040;
        step();
        redirectValid = 1'b0;
        idReady       = 1'b1;
        step();
        step();
        idReady = 1'b0;
        compared++;
        if (ifValid !== 1'b1 || ifPc !== 32'h40) begin
            mismatched++;
            $display("[TB] FAIL perf_monitor: got v=%0b pc=%h expected v=1 pc=00000040", ifValid, ifPc);
        end
        compared++;
        if (perfFetched !== 32'd10) begin
            mismatched++;
            $display("[TB] FAIL perf_fetched: got %0d expected 10", perfFetched);
        end
        compared++;
        if (perfStall !== 32'd4) begin
            mismatched++;
            $display("[TB] FAIL perf_stall: got %0d expected 4", perfStall);
        end
        step();
    endtask
`endif

    initial begin
        rstn          = 1'b0;
        idReady       = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'd0;
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back_redirect();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
